// File: rtl/id_issue_stage.sv
// Registered MIPS decode/issue stage with an internal load-use scoreboard.
// Optional feature: define ID_STALL_CNT_EN to build the load-use stall counter.
module id_issue_stage #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned LOAD_LAT       = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_pc,
  input  logic [31:0]               in_inst,
  input  logic                      flush,
  output logic                      reg_read_en_1,
  output logic                      reg_read_en_2,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_1,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_2,
  input  logic [DATA_WIDTH-1:0]     reg_data_1,
  input  logic [DATA_WIDTH-1:0]     reg_data_2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_pc,
  output logic [5:0]                out_op,
  output logic [5:0]                out_funct,
  output logic [4:0]                out_shamt,
  output logic [DATA_WIDTH-1:0]     out_rs_data,
  output logic [DATA_WIDTH-1:0]     out_rt_data,
  output logic [DATA_WIDTH-1:0]     out_imm,
  output logic                      out_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] out_wr_addr,
  output logic                      out_is_load,
  output logic                      out_is_store,
  output logic [31:0]               stall_cnt
);

  logic [5:0]                op;
  logic [REG_ADDR_WIDTH-1:0] rs, rt, rd, dst;
  logic                      use_rs, use_rt, has_wr, wr_en_c;
  logic                      is_load, is_store, zext;
  logic [DATA_WIDTH-1:0]     imm_ext;
  logic                      adv, hazard, src_hit, accept;

  logic [LOAD_LAT-1:0]       sb_v_q, sb_v_d;
  logic [REG_ADDR_WIDTH-1:0] sb_a_q [LOAD_LAT];
  logic [REG_ADDR_WIDTH-1:0] sb_a_d [LOAD_LAT];

  assign op       = in_inst[31:26];
  assign rs       = REG_ADDR_WIDTH'(in_inst[25:21]);
  assign rt       = REG_ADDR_WIDTH'(in_inst[20:16]);
  assign rd       = REG_ADDR_WIDTH'(in_inst[15:11]);
  assign is_load  = (op[5:3] == 3'b100);
  assign is_store = (op[5:3] == 3'b101);
  assign zext     = (op[5:2] == 4'b0011);
  assign imm_ext  = zext ? {{(DATA_WIDTH-16){1'b0}}, in_inst[15:0]}
                         : {{(DATA_WIDTH-16){in_inst[15]}}, in_inst[15:0]};

  // Instruction class -> source usage and writeback destination
  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    has_wr = 1'b0;
    dst    = '0;
    if (op == 6'b000000) begin
      use_rs = 1'b1;
      use_rt = 1'b1;
      has_wr = 1'b1;
      dst    = rd;
    end else if (op[5:3] == 3'b001 || is_load) begin
      use_rs = 1'b1;
      has_wr = 1'b1;
      dst    = rt;
    end else if (is_store || op[5:1] == 5'b00010) begin
      use_rs = 1'b1;
      use_rt = 1'b1;
    end else if (op == 6'b000011) begin
      has_wr = 1'b1;
      dst    = REG_ADDR_WIDTH'(5'd31);
    end
  end

  assign wr_en_c       = has_wr && (dst != '0);
  assign reg_read_en_1 = use_rs;
  assign reg_read_en_2 = use_rt;
  assign reg_addr_1    = rs;
  assign reg_addr_2    = rt;

  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < int'(LOAD_LAT); i++) begin
      if (sb_v_q[i] && ((use_rs && rs != '0 && sb_a_q[i] == rs) ||
                        (use_rt && rt != '0 && sb_a_q[i] == rt)))
        src_hit = 1'b1;
    end
  end

  assign adv      = !out_valid || out_ready;
  assign hazard   = in_valid && src_hit;
  assign in_ready = flush || (adv && !hazard);
  assign accept   = in_valid && in_ready && !flush;

  // Slot0 always tracks the load now in ID/EX, so a flush kills it before the shift
  always_comb begin
    sb_v_d = sb_v_q;
    sb_a_d = sb_a_q;
    if (adv || flush) begin
      for (int i = int'(LOAD_LAT) - 1; i > 0; i--) begin
        sb_v_d[i] = sb_v_q[i-1] && !(flush && i == 1);
        sb_a_d[i] = sb_a_q[i-1];
      end
      sb_v_d[0] = accept && is_load;
      sb_a_d[0] = rt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v_q <= '0;
      for (int i = 0; i < int'(LOAD_LAT); i++) sb_a_q[i] <= '0;
    end else begin
      sb_v_q <= sb_v_d;
      sb_a_q <= sb_a_d;
    end
  end

  // ID/EX bundle register; flush kills even under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_op       <= '0;
      out_funct    <= '0;
      out_shamt    <= '0;
      out_rs_data  <= '0;
      out_rt_data  <= '0;
      out_imm      <= '0;
      out_wr_en    <= 1'b0;
      out_wr_addr  <= '0;
      out_is_load  <= 1'b0;
      out_is_store <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= accept;
      if (accept) begin
        out_pc       <= in_pc;
        out_op       <= op;
        out_funct    <= in_inst[5:0];
        out_shamt    <= in_inst[10:6];
        out_rs_data  <= reg_data_1;
        out_rt_data  <= reg_data_2;
        out_imm      <= imm_ext;
        out_wr_en    <= wr_en_c;
        out_wr_addr  <= dst;
        out_is_load  <= is_load;
        out_is_store <= is_store;
      end
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else if (hazard && adv && !flush) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
// Self-checking bench for id_issue_stage: directed cases plus random traffic
// against a queue-based behavioural model of the issue rules.
module tb_id_issue_stage;
  localparam int LAT = 2;

  logic        clk, rst_n;
  logic        in_valid, in_ready, flush;
  logic [31:0] in_pc, in_inst;
  logic        reg_read_en_1, reg_read_en_2;
  logic [4:0]  reg_addr_1, reg_addr_2;
  logic [31:0] reg_data_1, reg_data_2;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_op, out_funct;
  logic [4:0]  out_shamt;
  logic [31:0] out_rs_data, out_rt_data, out_imm;
  logic        out_wr_en;
  logic [4:0]  out_wr_addr;
  logic        out_is_load, out_is_store;
  logic [31:0] stall_cnt;

  id_issue_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .LOAD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .reg_read_en_1(reg_read_en_1), .reg_read_en_2(reg_read_en_2),
    .reg_addr_1(reg_addr_1), .reg_addr_2(reg_addr_2), .reg_data_1(reg_data_1), .reg_data_2(reg_data_2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_funct(out_funct), .out_shamt(out_shamt), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
    .out_imm(out_imm), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .stall_cnt(stall_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign reg_data_1 = rf[reg_addr_1];
  assign reg_data_2 = rf[reg_addr_2];

  int total = 0;
  int bad   = 0;

  // Reference model state: expected ID/EX bundle and pending load destinations with remaining age
  bit          m_v, m_we, m_ld, m_st;
  logic [31:0] m_pc, m_rs, m_rt, m_imm, m_stall;
  logic [5:0]  m_op, m_funct;
  logic [4:0]  m_shamt, m_wa;
  int          q_dst[$];
  int          q_age[$];

  typedef struct {
    bit rs_u;
    bit rt_u;
    int dst;
  } dec_t;

  function automatic dec_t dec(input logic [31:0] i);
    dec_t d;
    int   op;
    op = int'(i[31:26]);
    d.rs_u = 0; d.rt_u = 0; d.dst = -1;
    if (op == 0) begin
      d.rs_u = 1; d.rt_u = 1; d.dst = int'(i[15:11]);
    end else if ((op >= 8 && op <= 15) || (op >= 32 && op <= 39)) begin
      d.rs_u = 1; d.dst = int'(i[20:16]);
    end else if ((op >= 40 && op <= 47) || op == 4 || op == 5) begin
      d.rs_u = 1; d.rt_u = 1;
    end else if (op == 3) begin
      d.dst = 31;
    end
    return d;
  endfunction

  function automatic logic [31:0] r_inst(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_inst(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_we = 0; m_ld = 0; m_st = 0;
    m_pc = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_stall = 0;
    m_op = 0; m_funct = 0; m_shamt = 0; m_wa = 0;
    q_dst = {}; q_age = {};
  endtask

  task automatic check_outs();
    chk("out_valid", 64'(out_valid), 64'(m_v));
    if (m_v) begin
      chk("out_pc", 64'(out_pc), 64'(m_pc));
      chk("out_op", 64'(out_op), 64'(m_op));
      chk("out_funct", 64'(out_funct), 64'(m_funct));
      chk("out_shamt", 64'(out_shamt), 64'(m_shamt));
      chk("out_rs_data", 64'(out_rs_data), 64'(m_rs));
      chk("out_rt_data", 64'(out_rt_data), 64'(m_rt));
      chk("out_imm", 64'(out_imm), 64'(m_imm));
      chk("out_wr_en", 64'(out_wr_en), 64'(m_we));
      chk("out_wr_addr", 64'(out_wr_addr), 64'(m_wa));
      chk("out_is_load", 64'(out_is_load), 64'(m_ld));
      chk("out_is_store", 64'(out_is_store), 64'(m_st));
    end
`ifdef ID_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`else
    chk("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
  endtask

  task automatic check_reset_outs();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_op", 64'(out_op), 64'd0);
    chk("rst_out_rs_data", 64'(out_rs_data), 64'd0);
    chk("rst_out_rt_data", 64'(out_rt_data), 64'd0);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_wr_en", 64'(out_wr_en), 64'd0);
    chk("rst_out_wr_addr", 64'(out_wr_addr), 64'd0);
    chk("rst_out_is_load", 64'(out_is_load), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registered outputs
  task automatic cyc(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                     input bit fl, input bit ordy, output bit acc);
    dec_t d;
    bit   adv, haz, rdy, ld;
    int   rs, rt, op;
    int   nd[$];
    int   na[$];
    in_valid = v; in_inst = inst; in_pc = pc; flush = fl; out_ready = ordy;
    d  = dec(inst);
    rs = int'(inst[25:21]);
    rt = int'(inst[20:16]);
    op = int'(inst[31:26]);
    ld = (op >= 32 && op <= 39);
    adv = !m_v || ordy;
    haz = 0;
    foreach (q_dst[k])
      if ((d.rs_u && rs != 0 && rs == q_dst[k]) || (d.rt_u && rt != 0 && rt == q_dst[k])) haz = 1;
    haz = haz && v;
    rdy = fl || (adv && !haz);
    acc = v && rdy && !fl;
    #2;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("rd_en1", 64'(reg_read_en_1), 64'(d.rs_u));
    chk("rd_en2", 64'(reg_read_en_2), 64'(d.rt_u));
    chk("rd_addr1", 64'(reg_addr_1), 64'(rs));
    chk("rd_addr2", 64'(reg_addr_2), 64'(rt));
    if (adv && haz && !fl) m_stall = m_stall + 32'd1;
    if (adv || fl) begin
      foreach (q_dst[k]) begin
        if (!(fl && q_age[k] == LAT) && q_age[k] > 1) begin
          nd.push_back(q_dst[k]);
          na.push_back(q_age[k] - 1);
        end
      end
      if (acc && ld) begin
        nd.push_back(rt);
        na.push_back(LAT);
      end
      q_dst = nd;
      q_age = na;
    end
    if (fl) m_v = 0;
    else if (adv) begin
      m_v = acc;
      if (acc) begin
        m_pc = pc; m_op = inst[31:26]; m_funct = inst[5:0]; m_shamt = inst[10:6];
        m_rs = rf[rs]; m_rt = rf[rt];
        m_imm = (op >= 12 && op <= 15) ? {16'd0, inst[15:0]} : {{16{inst[15]}}, inst[15:0]};
        m_we = d.dst > 0;
        m_wa = (d.dst >= 0) ? 5'(d.dst) : 5'd0;
        m_ld = ld;
        m_st = (op >= 40 && op <= 47);
      end
    end
    @(posedge clk);
    #1;
    check_outs();
  endtask

  initial begin
    bit          a;
    logic [31:0] lw8, add9, cur;
    logic [31:0] pc;
    int          ops[12];
    int          waits;
    ops = '{0, 8, 9, 12, 13, 15, 35, 43, 4, 5, 2, 3};
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    lw8  = i_inst(35, 1, 8, 0);
    add9 = r_inst(8, 2, 9, 32);
    rst_n = 0; in_valid = 0; in_inst = 0; in_pc = 0; flush = 0; out_ready = 1;
    model_reset();
    #22;
    check_reset_outs();
    rst_n = 1;
    pc = 32'h100;

    // Load-use: two bubbles then the dependent add issues
    cyc(1, lw8, pc, 0, 1, a);
    chk("lu_lw_issue", 64'(out_is_load), 64'd1);
    cyc(1, add9, pc + 4, 0, 1, a);
    chk("lu_bub1", 64'(out_valid), 64'd0);
    cyc(1, add9, pc + 4, 0, 1, a);
    chk("lu_bub2", 64'(out_valid), 64'd0);
    cyc(1, add9, pc + 4, 0, 1, a);
    chk("lu_issue", 64'(out_valid), 64'd1);
    chk("lu_pc", 64'(out_pc), 64'(pc + 4));
`ifdef ID_STALL_CNT_EN
    chk("lu_stall", 64'(stall_cnt), 64'd2);
`endif
    pc += 8;

    // Load to $0 creates no hazard and no writeback
    cyc(1, i_inst(35, 1, 0, 0), pc, 0, 1, a);
    chk("lw0_wr_en", 64'(out_wr_en), 64'd0);
    cyc(1, r_inst(0, 2, 9, 32), pc + 4, 0, 1, a);
    chk("lw0_add_issue", 64'(out_valid), 64'd1);
    chk("lw0_add_pc", 64'(out_pc), 64'(pc + 4));
    pc += 8;

    // Immediate extension
    cyc(1, i_inst(8, 0, 3, 16'hFFFF), pc, 0, 1, a);
    chk("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
    cyc(1, i_inst(13, 0, 3, 16'hFFFF), pc + 4, 0, 1, a);
    chk("ori_imm", 64'(out_imm), 64'h0000_FFFF);
    pc += 8;

    // Backpressure holds the bundle; release issues the next instruction
    cyc(1, r_inst(4, 5, 6, 33), pc, 0, 1, a);
    for (int k = 0; k < 3; k++) begin
      cyc(1, r_inst(5, 6, 7, 34), pc + 4, 0, 0, a);
      chk("bp_hold_pc", 64'(out_pc), 64'(pc));
    end
    cyc(1, r_inst(5, 6, 7, 34), pc + 4, 0, 1, a);
    chk("bp_release_pc", 64'(out_pc), 64'(pc + 4));
    pc += 8;

    // Flush kills the load, so the following add does not stall
    cyc(1, lw8, pc, 0, 1, a);
    cyc(1, r_inst(1, 1, 1, 32), pc + 4, 1, 1, a);
    chk("fl_killed", 64'(out_valid), 64'd0);
    cyc(1, add9, pc + 8, 0, 1, a);
    chk("fl_add_issue", 64'(out_valid), 64'd1);
    chk("fl_add_pc", 64'(out_pc), 64'(pc + 8));
    pc += 12;

    // Asynchronous reset mid-stream
    cyc(1, lw8, pc, 0, 1, a);
    rst_n = 0;
    #1;
    check_reset_outs();
    model_reset();
    #1;
    rst_n = 1;
    cyc(1, add9, pc + 4, 0, 1, a);
    chk("rst_add_issue", 64'(out_valid), 64'd1);
    chk("rst_add_pc", 64'(out_pc), 64'(pc + 4));
    pc += 8;

    // Random traffic; IF holds an instruction until it is taken or flushed
    cur = r_inst(1, 2, 3, 32);
    a = 1;
    waits = 0;
    for (int n = 0; n < 500; n++) begin
      bit v, fl, ordy;
      v    = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 11) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      if (a || fl || !v) begin
        cur = {6'(ops[$urandom_range(0, 11)]), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom), 6'($urandom)};
        pc += 4;
        waits = 0;
      end
      cyc(v, cur, pc, fl, ordy, a);
      if (v && !a && !fl) waits++;
      if (waits > 40) begin
        chk("rand_progress_timeout", 64'(waits), 64'd0);
        waits = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
